// File: rtl/ksa_pkg.sv
// Shared types, character constants and the message-character predicate for the RC4 key search.
// Pure definitions; no latency and no flow control.
// Not applicable: holds no logic that could stall.
package ksa_pkg;

    localparam int KEY_W = 24;

    localparam logic [7:0] CHAR_A_LO  = 8'h61;
    localparam logic [7:0] CHAR_Z_LO  = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        ARC_START,
        ARC_WAIT,
        CHECK,
        NEXT,
        DONE
    } key_search_state_t;

    function automatic logic is_msg_char(input logic [7:0] b);
        return ((b >= CHAR_A_LO) && (b <= CHAR_Z_LO)) || (b == CHAR_SPACE);
    endfunction

endpackage

// File: rtl/msg_checker.sv
// Scans RAM A bytes 0..MSG_LEN-1 after a go pulse and reports whether all are message characters.
// MSG_LEN+1 cycles from go to done; j+2 cycles on first bad byte j when KEY_SEARCH_EARLY_ABORT_EN is defined.
// No backpressure: one address per cycle, RAM read data assumed one cycle behind the address.
module msg_checker
    import ksa_pkg::*;
#(
    parameter int MSG_LEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] a_q,
    output logic [4:0] a_addr,
    output logic       done,
    output logic       ok
);

    localparam logic [4:0] LAST_ADDR = 5'(MSG_LEN - 1);

    logic [4:0] addr_cnt;
    logic       active;
    logic       cmp_vld;
    logic       last_q;
    logic       ok_q;
    logic       issuing;
    logic       byte_ok;
    logic       abort;

    assign issuing = go | active;
    assign byte_ok = is_msg_char(a_q);

`ifdef KEY_SEARCH_EARLY_ABORT_EN
    assign abort = cmp_vld & ~byte_ok;
`else
    assign abort = 1'b0;
`endif

    // ok folds in the byte being compared this cycle so the caller can act on done directly.
    assign done   = (cmp_vld & last_q) | abort;
    assign ok     = ok_q & (~cmp_vld | byte_ok);
    assign a_addr = addr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt <= '0;
            active   <= 1'b0;
            cmp_vld  <= 1'b0;
            last_q   <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            if (go)
                ok_q <= 1'b1;
            else if (cmp_vld)
                ok_q <= ok_q & byte_ok;

            // An abort drops any reads still in flight and parks the counter at 0.
            if (done) begin
                addr_cnt <= '0;
                active   <= 1'b0;
                cmp_vld  <= 1'b0;
                last_q   <= 1'b0;
            end else if (issuing) begin
                cmp_vld  <= 1'b1;
                last_q   <= (addr_cnt == LAST_ADDR);
                active   <= (addr_cnt != LAST_ADDR);
                addr_cnt <= (addr_cnt == LAST_ADDR) ? 5'd0 : addr_cnt + 5'd1;
            end else begin
                cmp_vld  <= 1'b0;
                last_q   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/key_search.sv
// Brute-force RC4 key search: steps keys through arcfour and checks each decrypted message (optional KEY_SEARCH_EARLY_ABORT_EN).
// Per key: arcfour time + MSG_LEN+4 cycles; CHECK shortens to j+2 cycles on bad byte j with early abort.
// start ignored while busy; waits indefinitely on the arc_finished rising edge.
module key_search
    import ksa_pkg::*;
#(
    parameter int               MSG_LEN   = 32,
    parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [KEY_W-1:0] key,
    output logic             arc_start,
    input  logic             arc_finished,
    output logic [4:0]       a_addr,
    input  logic [7:0]       a_q,
    output logic             a_rd_active,
    output logic             busy,
    output logic             found,
    output logic             failed,
    output logic [KEY_W-1:0] key_found
);

    key_search_state_t state;
    logic fin_q;
    logic chk_go;
    logic chk_done;
    logic chk_ok;

    msg_checker #(.MSG_LEN(MSG_LEN)) u_checker (
        .clk    (clk),
        .reset  (reset),
        .go     (chk_go),
        .a_q    (a_q),
        .a_addr (a_addr),
        .done   (chk_done),
        .ok     (chk_ok)
    );

    assign busy        = (state != IDLE) && (state != DONE);
    assign a_rd_active = (state == CHECK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            key       <= KEY_START;
            arc_start <= 1'b0;
            found     <= 1'b0;
            failed    <= 1'b0;
            key_found <= '0;
            fin_q     <= 1'b0;
            chk_go    <= 1'b0;
        end else begin
            fin_q     <= arc_finished;
            arc_start <= 1'b0;
            chk_go    <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        key       <= KEY_START;
                        found     <= 1'b0;
                        failed    <= 1'b0;
                        key_found <= '0;
                        arc_start <= 1'b1;
                        state     <= ARC_START;
                    end
                end
                ARC_START: state <= ARC_WAIT;
                // Only a fresh rising edge counts; a level left high from the last key is stale.
                ARC_WAIT: begin
                    if (arc_finished && !fin_q) begin
                        chk_go <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (chk_done) begin
                        if (chk_ok) begin
                            found     <= 1'b1;
                            key_found <= key;
                            state     <= DONE;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (key == KEY_MAX) begin
                        failed <= 1'b1;
                        state  <= DONE;
                    end else begin
                        key       <= key + 24'd1;
                        arc_start <= 1'b1;
                        state     <= ARC_START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_search.sv
// Directed bench for key_search: two instances (default key range and a 3-key range at the top of the space)
// driven by a behavioural arcfour/RAM A model whose message depends on the key being tried.
module tb_key_search;

    localparam int ARC_LAT = 6;
    localparam logic [255:0] MSG = "the quick brown fox jumps over t";
`ifdef KEY_SEARCH_EARLY_ABORT_EN
    localparam int EXP_LEN0 = 2;
    localparam int EXP_MAX0 = 1;
`else
    localparam int EXP_LEN0 = 33;
    localparam int EXP_MAX0 = 31;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  start_v = 2'b00;
    logic [1:0]  arc_start_v, fin_v, rd_v, busy_v, found_v, failed_v;
    logic [23:0] key_v [2];
    logic [23:0] key_found_v [2];
    logic [4:0]  addr_v [2];
    logic [7:0]  aq_v [2];

    logic [1:0]  fin_m = 2'b00;
    int          lat [2] = '{0, 0};
    logic [23:0] cur_key [2] = '{24'h0, 24'h0};
    logic        force_en = 1'b0;
    logic        force_val = 1'b0;
    logic [23:0] good_key [2] = '{24'hFFFFFF, 24'hFFFFFF};
    logic [4:0]  bad_pos [2] = '{5'd0, 5'd0};
    logic [7:0]  bad_val [2] = '{8'h41, 8'h41};

    int arc_tot [2] = '{0, 0};
    int run_cnt [2] = '{0, 0};
    int cur_len [2] = '{0, 0};
    int cur_max [2] = '{0, 0};
    int hist_len [2][64];
    int hist_max [2][64];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign fin_v[0] = force_en ? force_val : fin_m[0];
    assign fin_v[1] = fin_m[1];

    key_search dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .key(key_v[0]), .arc_start(arc_start_v[0]),
        .arc_finished(fin_v[0]), .a_addr(addr_v[0]), .a_q(aq_v[0]), .a_rd_active(rd_v[0]),
        .busy(busy_v[0]), .found(found_v[0]), .failed(failed_v[0]), .key_found(key_found_v[0])
    );

    key_search #(.KEY_START(24'h3FFFFD), .KEY_MAX(24'h3FFFFF)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .key(key_v[1]), .arc_start(arc_start_v[1]),
        .arc_finished(fin_v[1]), .a_addr(addr_v[1]), .a_q(aq_v[1]), .a_rd_active(rd_v[1]),
        .busy(busy_v[1]), .found(found_v[1]), .failed(failed_v[1]), .key_found(key_found_v[1])
    );

    function automatic logic [7:0] byte_of(input int i, input logic [23:0] k, input logic [4:0] a);
        logic [255:0] m;
        m = MSG;
        if (k != good_key[i] && a == bad_pos[i])
            return bad_val[i];
        return m[8*(31-int'(a)) +: 8];
    endfunction

    // arcfour stand-in plus registered-read RAM A
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            aq_v[i] <= byte_of(i, cur_key[i], addr_v[i]);
            if (reset) begin
                fin_m[i] <= 1'b0;
                lat[i]   <= 0;
            end else if (arc_start_v[i]) begin
                fin_m[i]   <= 1'b0;
                lat[i]     <= ARC_LAT;
                cur_key[i] <= key_v[i];
            end else if (lat[i] != 0) begin
                lat[i] <= lat[i] - 1;
                if (lat[i] == 1) fin_m[i] <= 1'b1;
            end
        end
    end

    // start-pulse counts and a history of CHECK window lengths / highest address
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            arc_tot[i] <= arc_tot[i] + int'(arc_start_v[i]);
            if (rd_v[i]) begin
                cur_len[i] <= cur_len[i] + 1;
                if (int'(addr_v[i]) > cur_max[i]) cur_max[i] <= int'(addr_v[i]);
            end else if (cur_len[i] != 0) begin
                hist_len[i][run_cnt[i] % 64] <= cur_len[i];
                hist_max[i][run_cnt[i] % 64] <= cur_max[i];
                run_cnt[i] <= run_cnt[i] + 1;
                cur_len[i] <= 0;
                cur_max[i] <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int i);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input string tag);
        int n;
        n = 0;
        while (busy_v[i] && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finish"}, 32'(busy_v[i]), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int r0;
        int n;
        logic [7:0]  bv [5] = '{8'h7B, 8'h1F, 8'h61, 8'h7A, 8'h20};
        logic [4:0]  bp [5] = '{5'd31, 5'd31, 5'd0, 5'd17, 5'd31};
        logic        be [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy",      32'(busy_v[0]),      32'd0);
        check("rst_key_a",     32'(key_v[0]),       32'h000000);
        check("rst_key_b",     32'(key_v[1]),       32'h3FFFFD);
        check("rst_arc_start", 32'(arc_start_v[0]), 32'd0);
        check("rst_addr",      32'(addr_v[0]),      32'd0);
        check("rst_rd",        32'(rd_v[0]),        32'd0);
        check("rst_found",     32'(found_v[0]),     32'd0);
        check("rst_failed",    32'(failed_v[0]),    32'd0);
        check("rst_key_found", 32'(key_found_v[0]), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // correct key at offset 2; wrong keys start with 'A'
        good_key[0] = 24'h000002; bad_pos[0] = 5'd0; bad_val[0] = 8'h41;
        a0 = arc_tot[0]; r0 = run_cnt[0];
        pulse_start(0);
        wait_idle(0, "k2");
        check("k2_arc_pulses", 32'(arc_tot[0] - a0),             32'd3);
        check("k2_found",      32'(found_v[0]),                 32'd1);
        check("k2_failed",     32'(failed_v[0]),                32'd0);
        check("k2_key_found",  32'(key_found_v[0]),             32'h000002);
        check("k2_checks",     32'(run_cnt[0] - r0),            32'd3);
        check("k0_check_len",  32'(hist_len[0][r0 % 64]),       32'(EXP_LEN0));
        check("k0_check_max",  32'(hist_max[0][r0 % 64]),       32'(EXP_MAX0));
        check("k2_check_len",  32'(hist_len[0][(r0 + 2) % 64]), 32'd33);
        check("k2_check_max",  32'(hist_max[0][(r0 + 2) % 64]), 32'd31);
        repeat (5) @(negedge clk);
        check("k2_done_hold",  32'(key_found_v[0]),             32'h000002);

        // exhaustion over 3FFFFD..3FFFFF with a backtick at byte 5
        bad_pos[1] = 5'd5; bad_val[1] = 8'h60;
        a0 = arc_tot[1];
        pulse_start(1);
        wait_idle(1, "exh");
        check("exh_arc_pulses", 32'(arc_tot[1] - a0), 32'd3);
        check("exh_failed",     32'(failed_v[1]),     32'd1);
        check("exh_found",      32'(found_v[1]),      32'd0);
        check("exh_key",        32'(key_v[1]),        32'h3FFFFF);

        // boundary characters, restarting from DONE each time
        for (int t = 0; t < 5; t++) begin
            bad_pos[1] = bp[t]; bad_val[1] = bv[t];
            a0 = arc_tot[1];
            pulse_start(1);
            wait_idle(1, "bnd");
            check($sformatf("bnd_%02h_found", bv[t]),  32'(found_v[1]),          32'(be[t]));
            check($sformatf("bnd_%02h_failed", bv[t]), 32'(failed_v[1]),         32'(!be[t]));
            check($sformatf("bnd_%02h_kf", bv[t]),     32'(key_found_v[1]),      be[t] ? 32'h3FFFFD : 32'd0);
            check($sformatf("bnd_%02h_arcs", bv[t]),   32'(arc_tot[1] - a0),     be[t] ? 32'd1 : 32'd3);
        end

        // reset during CHECK at key 5
        good_key[0] = 24'hFFFFFF; bad_pos[0] = 5'd3; bad_val[0] = 8'h41;
        pulse_start(0);
        n = 0;
        while (!(key_v[0] == 24'h5 && rd_v[0]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach_key5", 32'(rd_v[0]), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_busy",      32'(busy_v[0]),      32'd0);
        check("mid_key",       32'(key_v[0]),       32'd0);
        check("mid_arc_start", 32'(arc_start_v[0]), 32'd0);
        check("mid_addr",      32'(addr_v[0]),      32'd0);
        check("mid_rd",        32'(rd_v[0]),        32'd0);
        check("mid_found",     32'(found_v[0]),     32'd0);
        check("mid_failed",    32'(failed_v[0]),    32'd0);
        check("mid_key_found", 32'(key_found_v[0]), 32'd0);
        good_key[0] = 24'h000001;
        a0 = arc_tot[0];
        pulse_start(0);
        check("restart_key",   32'(key_v[0]),       32'd0);
        check("restart_pulse", 32'(arc_start_v[0]), 32'd1);
        wait_idle(0, "restart");
        check("restart_found", 32'(key_found_v[0]), 32'h000001);
        check("restart_arcs",  32'(arc_tot[0] - a0), 32'd2);

        // stale arc_finished level held across ARC_START
        good_key[0] = 24'h000000;
        force_en = 1'b1; force_val = 1'b1;
        a0 = arc_tot[0]; r0 = run_cnt[0];
        pulse_start(0);
        repeat (30) @(negedge clk);
        check("stale_no_check", 32'(run_cnt[0] - r0 + int'(rd_v[0])), 32'd0);
        check("stale_busy",     32'(busy_v[0]), 32'd1);
        pulse_start(0);
        repeat (3) @(negedge clk);
        check("stale_ign_start", 32'(arc_tot[0] - a0), 32'd1);
        check("stale_ign_rd",    32'(rd_v[0]),         32'd0);
        force_val = 1'b0;
        @(negedge clk);
        force_val = 1'b1;
        @(negedge clk);
        check("stale_edge_check", 32'(rd_v[0]), 32'd1);
        force_en = 1'b0;
        wait_idle(0, "stale");
        check("stale_found",     32'(found_v[0]),      32'd1);
        check("stale_key_found", 32'(key_found_v[0]),  32'd0);
        check("stale_arcs",      32'(arc_tot[0] - a0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
